// File: rtl/bcd_counter_n.sv
// bcd_counter_n
//
// Multi-digit BCD counter with a programmable terminal value. Counts up
// from 0 to TOP and wraps to 0; optionally counts down from 0 to TOP. A
// synchronous parallel load takes priority over counting. Illegal load
// values (a digit above 9, or a value above TOP) load zero instead.
// Stages cascade by tying one stage's z to the next stage's en.
//
// Optional feature macro: BCD_COUNTER_UPDOWN_EN
//   defined   -> the up port selects increment (1) or decrement (0)
//   undefined -> always increments; the up port is ignored
//
// Parameters:
//   DIGITS  number of BCD digits (1..8)
//   TOP     terminal value as a decimal integer (1..10**DIGITS-1)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (q = 0, wrapped = 0)
//   en       count enable
//   up       direction (1 = up, 0 = down), used only with the macro
//   load     synchronous parallel load, higher priority than en
//   d        BCD load value, least significant digit in d[3:0]
//   q        registered BCD count
//   z        combinational terminal-count carry/borrow
//   wrapped  sticky flag, set on wrap, cleared by reset or load

module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int TOP    = 10**DIGITS - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                z,
  output logic                wrapped
);

  localparam int W = 4 * DIGITS;

  // Converts the decimal TOP parameter into its BCD image at elaboration.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] TOP_BCD = to_bcd(TOP);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_n: DIGITS must be in 1..8");
  end

  if (TOP < 1 || TOP > 10**DIGITS - 1) begin : g_bad_top
    $error("bcd_counter_n: TOP must be in 1..10**DIGITS-1");
  end

  logic [W-1:0] q_q, q_d;
  logic         wrapped_q, wrapped_d;
  logic         up_eff;
  logic         d_legal;
  logic         at_top, at_zero;
  logic [W-1:0] q_inc;

`ifdef BCD_COUNTER_UPDOWN_EN
  logic [W-1:0] q_dec;
  assign up_eff = up;
`else
  // Port kept for source compatibility; direction is fixed to up.
  logic unused_up;
  assign unused_up = up;
  assign up_eff    = 1'b1;
`endif

  assign at_top  = (q_q == TOP_BCD);
  assign at_zero = (q_q == '0);

  // With every digit in 0..9, plain unsigned comparison of the BCD vectors
  // orders them the same way as their decimal values.
  always_comb begin
    d_legal = (d <= TOP_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) begin
        d_legal = 1'b0;
      end
    end
  end

  // Decimal increment: a digit moves only when all lower digits are 9.
  always_comb begin
    logic carry;
    q_inc = q_q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        q_inc[4*i +: 4] = (q_q[4*i +: 4] == 4'd9) ? 4'd0 : q_q[4*i +: 4] + 4'd1;
      end
      carry = carry & (q_q[4*i +: 4] == 4'd9);
    end
  end

`ifdef BCD_COUNTER_UPDOWN_EN
  // Decimal decrement: a digit moves only when all lower digits are 0.
  always_comb begin
    logic borrow;
    q_dec  = q_q;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        q_dec[4*i +: 4] = (q_q[4*i +: 4] == 4'd0) ? 4'd9 : q_q[4*i +: 4] - 4'd1;
      end
      borrow = borrow & (q_q[4*i +: 4] == 4'd0);
    end
  end
`endif

  // Next state: load beats en beats hold; wraps set the sticky flag.
  always_comb begin
    q_d       = q_q;
    wrapped_d = wrapped_q;
    if (load) begin
      q_d       = d_legal ? d : '0;
      wrapped_d = 1'b0;
    end else if (en) begin
`ifdef BCD_COUNTER_UPDOWN_EN
      if (up_eff) begin
        if (at_top) begin
          q_d       = '0;
          wrapped_d = 1'b1;
        end else begin
          q_d = q_inc;
        end
      end else begin
        if (at_zero) begin
          q_d       = TOP_BCD;
          wrapped_d = 1'b1;
        end else begin
          q_d = q_dec;
        end
      end
`else
      if (at_top) begin
        q_d       = '0;
        wrapped_d = 1'b1;
      end else begin
        q_d = q_inc;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign q       = q_q;
  assign wrapped = wrapped_q;
  assign z       = en & ~load & (up_eff ? at_top : at_zero);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Testbench for bcd_counter_n: a two-digit TOP=59 instance checked every
// cycle against a decimal-integer reference model, plus a cascaded pair of
// single-digit stages (TOP=9 feeding TOP=5) forming a 0..59 chain.

module tb_bcd_counter_n;

  localparam int TOP = 59;

`ifdef BCD_COUNTER_UPDOWN_EN
  localparam bit UPDOWN = 1'b1;
`else
  localparam bit UPDOWN = 1'b0;
`endif

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       en, up, load;
  logic [7:0] d;
  logic [7:0] q;
  logic       z, wrapped;

  logic       c_en;
  logic [3:0] q_lo, q_hi;
  logic       z_lo, z_hi, w_lo, w_hi;

  int checks = 0;
  int errors = 0;

  // Reference model state: count held as a plain decimal integer.
  int m_val;
  bit m_wrapped;

  bcd_counter_n #(.DIGITS(2), .TOP(TOP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .d(d), .q(q), .z(z), .wrapped(wrapped)
  );

  bcd_counter_n #(.DIGITS(1), .TOP(9)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .load(1'b0),
    .d(4'h0), .q(q_lo), .z(z_lo), .wrapped(w_lo)
  );

  bcd_counter_n #(.DIGITS(1), .TOP(5)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(z_lo), .up(1'b1), .load(1'b0),
    .d(4'h0), .q(q_hi), .z(z_hi), .wrapped(w_hi)
  );

  // Clock can be held still to show that reset needs no edge.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic record(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: load/count rules applied to a decimal integer.
  always @(posedge clk or negedge rst_n) begin
    int  hi_d, lo_d;
    bit  dir_up;
    if (!rst_n) begin
      m_val     <= 0;
      m_wrapped <= 1'b0;
    end else if (load) begin
      hi_d = int'(d[7:4]);
      lo_d = int'(d[3:0]);
      if (hi_d <= 9 && lo_d <= 9 && hi_d * 10 + lo_d <= TOP) m_val <= hi_d * 10 + lo_d;
      else m_val <= 0;
      m_wrapped <= 1'b0;
    end else if (en) begin
      dir_up = UPDOWN ? up : 1'b1;
      if (dir_up) begin
        if (m_val == TOP) begin
          m_val     <= 0;
          m_wrapped <= 1'b1;
        end else m_val <= m_val + 1;
      end else begin
        if (m_val == 0) begin
          m_val     <= TOP;
          m_wrapped <= 1'b1;
        end else m_val <= m_val - 1;
      end
    end
  end

  // Every falling edge the DUT must agree with the model.
  always @(negedge clk) begin
    bit dir_up;
    bit exp_z;
    dir_up = UPDOWN ? up : 1'b1;
    exp_z  = en & ~load & (dir_up ? (m_val == TOP) : (m_val == 0));
    record("model_q", 32'(q), 32'(to_bcd(m_val)));
    record("model_wrapped", 32'(wrapped), 32'(m_wrapped));
    record("model_z", 32'(z), 32'(exp_z));
  end

  task automatic applyStimulus(input logic en_v, input logic load_v, input logic up_v,
                               input logic [7:0] d_v);
    @(posedge clk);
    #1;
    en   = en_v;
    load = load_v;
    up   = up_v;
    d    = d_v;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_q,
                             input logic exp_z, input logic exp_w);
    @(negedge clk);
    record({name, "_q"}, 32'(q), 32'(exp_q));
    record({name, "_z"}, 32'(z), 32'(exp_z));
    record({name, "_wrapped"}, 32'(wrapped), 32'(exp_w));
  endtask

  initial begin
    int         pulses;
    int         pulse_edge;
    logic [7:0] rd;

    clk_run = 1'b0;
    rst_n   = 1'b0;
    en      = 1'b1;
    up      = 1'b1;
    load    = 1'b0;
    d       = 8'h00;
    c_en    = 1'b0;

    // Reset with the clock stopped.
    #10;
    record("reset_q", 32'(q), 32'h00);
    record("reset_wrapped", 32'(wrapped), 32'h0);
    record("reset_z", 32'(z), 32'h0);
    rst_n = 1'b1;
    #5;
    clk_run = 1'b1;
    repeat (4) @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("after_5_edges", 8'h05, 1'b0, 1'b0);

    // Up wrap at TOP=59.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h58);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("at_58", 8'h58, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("at_59", 8'h59, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("wrap_up", 8'h00, 1'b0, 1'b1);

    // Illegal loads give zero and clear the sticky flag.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h7A);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h60);
    checkOutput("load_7A", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h42);
    checkOutput("load_60", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("load_42", 8'h42, 1'b0, 1'b0);

    // Decimal carry 09 -> 10.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h09);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("carry_pre", 8'h09, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("carry_post", 8'h10, 1'b0, 1'b0);

`ifdef BCD_COUNTER_UPDOWN_EN
    // Down wrap and borrow.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("down_01", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("down_00", 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap_down", 8'h59, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("borrow_pre", 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("borrow_post", 8'h09, 1'b0, 1'b0);
`endif

    // Load/en collision: load wins, z suppressed.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h59);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30);
    checkOutput("collide", 8'h59, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("collide_post", 8'h30, 1'b0, 1'b0);

    // Reset mid-count takes effect without a clock edge.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    record("midreset_q", 32'(q), 32'h00);
    record("midreset_wrapped", 32'(wrapped), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Cascade: 60 enabled edges through a 0..9 and 0..5 chain.
    @(posedge clk);
    #1;
    c_en       = 1'b1;
    pulses     = 0;
    pulse_edge = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (z_hi) begin
        pulses++;
        pulse_edge = k;
      end
      @(posedge clk);
    end
    #1;
    c_en = 1'b0;
    @(negedge clk);
    record("cascade_lo_q", 32'(q_lo), 32'h0);
    record("cascade_hi_q", 32'(q_hi), 32'h0);
    record("cascade_hi_wrapped", 32'(w_hi), 32'h1);
    record("cascade_pulses", 32'(pulses), 32'd1);
    record("cascade_pulse_edge", 32'(pulse_edge), 32'd60);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1) == 1) rd = {4'($urandom_range(9)), 4'($urandom_range(9))};
      else rd = 8'($urandom);
      applyStimulus($urandom_range(3) != 0, $urandom_range(9) == 0,
                    1'($urandom_range(1)), rd);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
